// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } arb_state_e;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    // Identifies one of the two requesters.
    typedef logic req_idx_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way pick: forced requester 1 first, then fixed or round-robin tie-break.
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  req_idx_t last_winner,
    input  logic     mode,
    input  logic     force1,
    output logic     pick0,
    output logic     pick1
);

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (force1 && req1) begin
            pick1 = 1'b1;
        end else if (req0 && req1) begin
            // mode=1 is fixed priority; otherwise favour whoever did not win last.
            if (mode || (last_winner == 1'b1)) begin
                pick0 = 1'b1;
            end else begin
                pick1 = 1'b1;
            end
        end else begin
            pick0 = req0;
            pick1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_mem port between the MEM stage (0) and the loader (1) with burst locking.
// Optional starvation breaker enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    req_idx_t          last_q, last_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rvalid0_q, rvalid1_q;
    logic              pick0, pick1;
    logic              starve0, starve1;
    logic              xfer0, xfer1;

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic [WaitW-1:0] wait0_q, wait0_d, wait1_q, wait1_d;

    assign starve0 = req0 && (wait0_q == WaitMax);
    assign starve1 = req1 && (wait1_q == WaitMax);

    always_comb begin
        wait0_d = '0;
        wait1_d = '0;
        if (req0 && !gnt0) begin
            wait0_d = (wait0_q == WaitMax) ? wait0_q : wait0_q + WaitW'(1);
        end
        if (req1 && !gnt1) begin
            wait1_d = (wait1_q == WaitMax) ? wait1_q : wait1_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign starve0 = 1'b0;
    assign starve1 = 1'b0;
`endif

    arb_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_q),
        .mode        (PRIO_MODE == PRIO_FIXED),
        .force1      (starve1),
        .pick0       (pick0),
        .pick1       (pick1)
    );

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            StOwn0:  gnt0 = req0;
            StOwn1:  gnt1 = req1;
            default: begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
        endcase
        // A starved requester overrides both priority and any lock.
        if (starve1) begin
            gnt0 = pick0;
            gnt1 = pick1;
        end else if (starve0) begin
            gnt0 = 1'b1;
            gnt1 = 1'b0;
        end
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign xfer0 = req0 && gnt0;
    assign xfer1 = req1 && gnt1;

    assign mem_r     = (xfer0 && !we0) || (xfer1 && !we1);
    assign mem_w     = (xfer0 && we0) || (xfer1 && we1);
    assign mem_addr  = xfer0 ? addr0 : (xfer1 ? addr1 : addr_q);
    assign mem_wdata = xfer0 ? wdata0 : (xfer1 ? wdata1 : wdata_q);
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = mem_rdata;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (xfer0) begin
            last_d = 1'b0;
        end else if (xfer1) begin
            last_d = 1'b1;
        end
        if (starve0 || starve1) begin
            if (xfer1) begin
                state_d = lock1 ? StOwn1 : StIdle;
            end else if (xfer0) begin
                state_d = lock0 ? StOwn0 : StIdle;
            end
        end else begin
            unique case (state_q)
                StOwn0: if (!lock0) state_d = StIdle;
                StOwn1: if (!lock1) state_d = StIdle;
                default: begin
                    if (xfer0 && lock0) begin
                        state_d = StOwn0;
                    end else if (xfer1 && lock1) begin
                        state_d = StOwn1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            rvalid0_q <= xfer0 && !we0;
            rvalid1_q <= xfer1 && !we1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share stimulus; each is checked
// cycle by cycle against a transaction-level model of ownership, grants and memory.
module tb_dmem_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          gnt0_a    [2];
    logic          gnt1_a    [2];
    logic          rvalid0_a [2];
    logic          rvalid1_a [2];
    logic          mem_r_a   [2];
    logic          mem_w_a   [2];
    logic [AW-1:0] mem_addr_a  [2];
    logic [DW-1:0] mem_wdata_a [2];
    logic [DW-1:0] rdata_a     [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 is fixed priority; each has its own memory.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [16];
        logic [DW-1:0] mem_rdata;

        dmem_arbiter #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .PRIO_MODE (g),
            .MAX_WAIT  (MAX_WAIT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req0      (req0),
            .req1      (req1),
            .we0       (we0),
            .we1       (we1),
            .lock0     (lock0),
            .lock1     (lock1),
            .addr0     (addr0),
            .addr1     (addr1),
            .wdata0    (wdata0),
            .wdata1    (wdata1),
            .gnt0      (gnt0_a[g]),
            .gnt1      (gnt1_a[g]),
            .rvalid0   (rvalid0_a[g]),
            .rvalid1   (rvalid1_a[g]),
            .rdata     (rdata_a[g]),
            .mem_r     (mem_r_a[g]),
            .mem_w     (mem_w_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata)
        );

        always @(posedge clk) begin
            if (mem_w_a[g]) mem[mem_addr_a[g][3:0]] <= mem_wdata_a[g];
            if (mem_r_a[g]) mem_rdata <= mem[mem_addr_a[g][3:0]];
        end
    end

    // Reference model state, per instance.
    int            owner [2];  // -1 = nobody
    bit            last  [2];
    bit            pv0   [2];
    bit            pv1   [2];
    logic [DW-1:0] pdata [2];
    logic [AW-1:0] sh_addr  [2];
    logic [DW-1:0] sh_wdata [2];
    logic [DW-1:0] mmem [2][16];
    int            w0 [2];
    int            w1 [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i]    = -1;
            last[i]     = 1'b1;
            pv0[i]      = 1'b0;
            pv1[i]      = 1'b0;
            pdata[i]    = '0;
            sh_addr[i]  = '0;
            sh_wdata[i] = '0;
            w0[i]       = 0;
            w1[i]       = 0;
        end
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs of both instances against the model, then advance the model.
    task automatic eval();
        #2;
        for (int i = 0; i < 2; i++) begin
            bit            e0, e1, s0, s1, we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            e0 = 0;
            e1 = 0;
            if (owner[i] == 0) e0 = req0;
            else if (owner[i] == 1) e1 = req1;
            else if (req0 && req1) begin
                if (i == 1 || last[i]) e0 = 1; else e1 = 1;
            end else begin
                e0 = req0;
                e1 = req1;
            end
            s1 = req1 && (w1[i] >= MAX_WAIT);
            s0 = req0 && (w0[i] >= MAX_WAIT);
            if (s1) begin e0 = 0; e1 = 1; end
            else if (s0) begin e0 = 1; e1 = 0; end

            a  = e0 ? addr0 : (e1 ? addr1 : sh_addr[i]);
            d  = e0 ? wdata0 : (e1 ? wdata1 : sh_wdata[i]);
            we = e0 ? we0 : we1;

            check($sformatf("gnt0[%0d]", i), gnt0_a[i], e0);
            check($sformatf("gnt1[%0d]", i), gnt1_a[i], e1);
            check($sformatf("mem_r[%0d]", i), mem_r_a[i], (e0 || e1) && !we);
            check($sformatf("mem_w[%0d]", i), mem_w_a[i], (e0 || e1) && we);
            check($sformatf("mem_addr[%0d]", i), mem_addr_a[i], a);
            check($sformatf("mem_wdata[%0d]", i), mem_wdata_a[i], d);
            check($sformatf("rvalid0[%0d]", i), rvalid0_a[i], pv0[i]);
            check($sformatf("rvalid1[%0d]", i), rvalid1_a[i], pv1[i]);
            if (pv0[i] || pv1[i]) check($sformatf("rdata[%0d]", i), rdata_a[i], pdata[i]);

            if (e0 || e1) begin
                if (we) mmem[i][a[3:0]] = d;
                sh_addr[i]  = a;
                sh_wdata[i] = d;
            end
            pv0[i]   = e0 && !we0;
            pv1[i]   = e1 && !we1;
            pdata[i] = mmem[i][a[3:0]];

            if (s0 || s1) begin
                if (e1) owner[i] = lock1 ? 1 : -1;
                else    owner[i] = lock0 ? 0 : -1;
            end else if (owner[i] == 0) begin
                if (!lock0) owner[i] = -1;
            end else if (owner[i] == 1) begin
                if (!lock1) owner[i] = -1;
            end else if (e0 && lock0) owner[i] = 0;
            else if (e1 && lock1) owner[i] = 1;

            if (e0) last[i] = 1'b0;
            else if (e1) last[i] = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
            w0[i] = (!req0 || e0) ? 0 : ((w0[i] >= MAX_WAIT) ? MAX_WAIT : w0[i] + 1);
            w1[i] = (!req1 || e1) ? 0 : ((w1[i] >= MAX_WAIT) ? MAX_WAIT : w1[i] + 1);
`endif
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_gnt0[%0d]", i), gnt0_a[i], 0);
            check($sformatf("rst_gnt1[%0d]", i), gnt1_a[i], 0);
            check($sformatf("rst_rvalid[%0d]", i), {rvalid0_a[i], rvalid1_a[i]}, 0);
            check($sformatf("rst_mem_rw[%0d]", i), {mem_r_a[i], mem_w_a[i]}, 0);
            check($sformatf("rst_mem_addr[%0d]", i), mem_addr_a[i], 0);
            check($sformatf("rst_mem_wdata[%0d]", i), mem_wdata_a[i], 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) mmem[i][j] = '0;
        do_reset();

        // Preload every word through the loader; address 4 holds 9.
        for (int k = 0; k < 16; k++) begin
            idle_inputs();
            req1 = 1; we1 = 1; addr1 = AW'(k);
            wdata1 = (k == 4) ? 32'd9 : $urandom;
            eval();
            tick();
        end

        // Single read of address 4.
        idle_inputs();
        req0 = 1; addr0 = 4;
        eval();
        check("single_gnt0", gnt0_a[0], 1);
        check("single_mem_addr", mem_addr_a[0], 4);
        tick();
        idle_inputs();
        eval();
        check("single_rvalid0", rvalid0_a[0], 1);
        check("single_rdata", rdata_a[0], 9);
        tick();

        // Tie of writes right after reset: round-robin alternates starting with 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0 = 1; we0 = 1; addr0 = AW'(8 + k); wdata0 = $urandom;
            req1 = 1; we1 = 1; addr1 = AW'(12 + k); wdata1 = $urandom;
            eval();
            check("rr_gnt0", gnt0_a[0], (k % 2) == 0);
            check("fixed_tie_gnt0", gnt0_a[1], 1);
            tick();
        end

        // Fixed priority: requester 1 waits until req0 drops.
        for (int k = 0; k < 6; k++) begin
            req0 = (k < 5); we0 = 0; addr0 = AW'(k);
            req1 = 1; we1 = 0; addr1 = 7;
            eval();
            check("fixed_gnt1", gnt1_a[1], k == 5);
            tick();
        end
        idle_inputs();
        eval();
        tick();

        // Locked burst by the loader while requester 0 keeps asking.
        for (int k = 0; k < 4; k++) begin
            req1 = 1; we1 = 1; lock1 = (k < 3); addr1 = AW'(2 + k); wdata1 = $urandom;
            req0 = (k > 0); we0 = 0; addr0 = 7;
            eval();
            for (int i = 0; i < 2; i++) begin
                check("burst_gnt1", gnt1_a[i], 1);
                check("burst_gnt0", gnt0_a[i], 0);
            end
            tick();
        end
        req1 = 0; lock1 = 0;
        eval();
        check("after_burst_gnt0", gnt0_a[0], 1);
        check("after_burst_gnt0f", gnt0_a[1], 1);
        tick();

        // Reset lands while a read is in flight.
        idle_inputs();
        req0 = 1; addr0 = 4;
        eval();
        check("mid_read_gnt0", gnt0_a[0], 1);
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        idle_inputs();
        eval();
        check("mid_read_rvalid0", rvalid0_a[0], 0);
        tick();
        req0 = 1; addr0 = 1; req1 = 1; addr1 = 2;
        eval();
        check("post_reset_tie", gnt0_a[0], 1);
        tick();

`ifdef DMEM_ARB_STARVE_EN
        do_reset();
        for (int k = 0; k < 11; k++) begin
            req0 = 1; we0 = 0; addr0 = 1;
            req1 = 1; we1 = 1; addr1 = 3; wdata1 = $urandom;
            eval();
            check("starve_gnt1", gnt1_a[1], k == 8);
            check("starve_gnt0", gnt0_a[1], k != 8);
            tick();
        end
`endif

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            req0   = ($urandom_range(0, 9) < 7);
            req1   = ($urandom_range(0, 9) < 6);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            lock0  = ($urandom_range(0, 3) == 0);
            lock1  = ($urandom_range(0, 3) == 0);
            addr0  = AW'($urandom_range(0, 15));
            addr1  = AW'($urandom_range(0, 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            eval();
            tick();
        end
        idle_inputs();
        eval();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
